// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: pulls a/b pairs, drives one MAC and feeds
// each partial sum back as the next c operand until the job is done.
module mac_seq_ctrl #(
  parameter int bw      = 4,
  parameter int psum_bw = 16,
  parameter int len_bw  = 8,
  parameter int MAC_LAT = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [len_bw-1:0]  len,
  input  logic [psum_bw-1:0] init_c,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [bw-1:0]      in_a,
  input  logic [bw-1:0]      in_b,
  output logic [bw-1:0]      mac_a,
  output logic [bw-1:0]      mac_b,
  output logic [psum_bw-1:0] mac_c,
  input  logic [psum_bw-1:0] mac_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [psum_bw-1:0] out_psum,
  output logic               busy
);

  localparam int WCW = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [psum_bw-1:0] psum_q, psum_d;
  logic [bw-1:0]      a_q, a_d;
  logic [bw-1:0]      b_q, b_d;
  logic [len_bw-1:0]  tcnt_q, tcnt_d;
  logic [len_bw-1:0]  len_q, len_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;

  always_comb begin
    state_d = state_q;
    psum_d  = psum_q;
    a_d     = a_q;
    b_d     = b_q;
    tcnt_d  = tcnt_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          psum_d  = init_c;
          len_d   = len;
          tcnt_d  = '0;
          state_d = (len == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          wcnt_d  = WCW'(MAC_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - WCW'(1);
        end else begin
          psum_d  = mac_out;
          tcnt_d  = tcnt_q + len_bw'(1);
          state_d = (tcnt_q == len_q - len_bw'(1)) ? DONE : FETCH;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      psum_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tcnt_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      psum_q  <= psum_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tcnt_q  <= tcnt_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign mac_a     = a_q;
  assign mac_b     = b_q;
  assign mac_c     = psum_q;
  assign out_psum  = psum_q;
  assign in_ready  = (state_q == FETCH);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with behavioural MACs at
// latencies 1 (main), 0 and 2 (latency sweep).
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  len;
  logic [15:0] init_c;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a, in_b;
  logic [3:0]  mac_a, mac_b;
  logic [15:0] mac_c, mac_out;
  logic        out_valid, out_ready;
  logic [15:0] out_psum;
  logic        busy;

  logic        start_s, out_ready_s;
  logic [7:0]  len_s;
  logic [15:0] init_s;
  logic        rdy_l0, rdy_l2, ov_l0, ov_l2, busy_l0, busy_l2;
  logic [3:0]  ia_l0, ib_l0, ia_l2, ib_l2;
  logic [3:0]  ma_l0, mb_l0, ma_l2, mb_l2;
  logic [15:0] mc_l0, mc_l2, mo_l0, mo_l2, p2_l2, ps_l0, ps_l2;
  int          k0, k2;

  logic [3:0]  va[8], vb[8];
  logic [3:0]  sa[4], sb[4];
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mac_f(
    input logic [15:0] c, input logic [3:0] a, input logic [3:0] b);
    logic signed [15:0] aa, bb;
    aa = {12'b0, a};
    bb = {{12{b[3]}}, b};
    return c + 16'(aa * bb);
  endfunction

  mac_seq_ctrl #(.MAC_LAT(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .len(len),
    .init_c(init_c), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_a(mac_a), .mac_b(mac_b),
    .mac_c(mac_c), .mac_out(mac_out), .out_valid(out_valid),
    .out_ready(out_ready), .out_psum(out_psum), .busy(busy)
  );

  mac_seq_ctrl #(.MAC_LAT(0)) u_l0 (
    .clk(clk), .reset_n(reset_n), .start(start_s), .len(len_s),
    .init_c(init_s), .in_valid(1'b1), .in_ready(rdy_l0),
    .in_a(ia_l0), .in_b(ib_l0), .mac_a(ma_l0), .mac_b(mb_l0),
    .mac_c(mc_l0), .mac_out(mo_l0), .out_valid(ov_l0),
    .out_ready(out_ready_s), .out_psum(ps_l0), .busy(busy_l0)
  );

  mac_seq_ctrl #(.MAC_LAT(2)) u_l2 (
    .clk(clk), .reset_n(reset_n), .start(start_s), .len(len_s),
    .init_c(init_s), .in_valid(1'b1), .in_ready(rdy_l2),
    .in_a(ia_l2), .in_b(ib_l2), .mac_a(ma_l2), .mac_b(mb_l2),
    .mac_c(mc_l2), .mac_out(mo_l2), .out_valid(ov_l2),
    .out_ready(out_ready_s), .out_psum(ps_l2), .busy(busy_l2)
  );

  always @(posedge clk) mac_out <= mac_f(mac_c, mac_a, mac_b);
  assign mo_l0 = mac_f(mc_l0, ma_l0, mb_l0);
  always @(posedge clk) begin
    p2_l2 <= mac_f(mc_l2, ma_l2, mb_l2);
    mo_l2 <= p2_l2;
  end

  always @(posedge clk) begin
    if (start_s) begin
      k0 <= 0;
      k2 <= 0;
    end else begin
      if (rdy_l0) k0 <= k0 + 1;
      if (rdy_l2) k2 <= k2 + 1;
    end
  end
  assign ia_l0 = sa[k0[1:0]];
  assign ib_l0 = sb[k0[1:0]];
  assign ia_l2 = sa[k2[1:0]];
  assign ib_l2 = sb[k2[1:0]];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] model(input int n,
                                        input logic [15:0] c0);
    logic [15:0] acc;
    acc = c0;
    for (int i = 0; i < n; i++) acc = mac_f(acc, va[i], vb[i]);
    return acc;
  endfunction

  task automatic run_job(input int n, input logic [15:0] c0,
                         input bit rnd, output int cyc,
                         output bit saw_rdy);
    int  k;
    bit  acc;
    k = 0;
    saw_rdy = 0;
    start = 1'b1;
    len = n[7:0];
    init_c = c0;
    in_a = va[0];
    in_b = vb[0];
    in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    tick;
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 300) begin
      acc = in_valid && in_ready;
      if (in_ready) saw_rdy = 1;
      tick;
      cyc++;
      if (acc) k++;
      in_a = va[k % 8];
      in_b = vb[k % 8];
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    in_valid = 1'b0;
    if (!out_valid) chk("job_timeout", 32'(cyc), 32'(0));
  endtask

  initial begin
    int          cyc, c0c, c2c;
    bit          saw;
    logic [15:0] exp, hold;

    reset_n = 1'b0;
    start = 1'b0;
    len = '0;
    init_c = '0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    start_s = 1'b0;
    out_ready_s = 1'b0;
    len_s = '0;
    init_s = '0;
    for (int i = 0; i < 4; i++) begin
      sa[i] = '0;
      sb[i] = '0;
    end
    repeat (2) tick;
    reset_n = 1'b1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_psum", out_psum, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mac_ab", {mac_a, mac_b}, 0);

    // basic dot product
    va[0] = 4'd15; vb[0] = 4'h8;
    va[1] = 4'd7;  vb[1] = 4'd7;
    va[2] = 4'd1;  vb[2] = 4'hF;
    run_job(3, 16'h0000, 0, cyc, saw);
    chk("basic_psum", out_psum, 16'hFFB8);
    chk("basic_latency", 32'(cyc), 10);
    chk("basic_busy", busy, 1);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("basic_release", {out_valid, busy}, 0);

    // zero length job
    run_job(0, 16'h1234, 0, cyc, saw);
    chk("zero_latency", 32'(cyc), 1);
    chk("zero_psum", out_psum, 16'h1234);
    chk("zero_no_ready", saw, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // backpressure on both sides, start in DONE ignored
    va[0] = 4'd9;  vb[0] = 4'h9;
    va[1] = 4'd3;  vb[1] = 4'd5;
    va[2] = 4'd12; vb[2] = 4'hC;
    va[3] = 4'd6;  vb[3] = 4'd7;
    exp = model(4, 16'h0100);
    run_job(4, 16'h0100, 1, cyc, saw);
    chk("bp_psum", out_psum, exp);
    hold = out_psum;
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len = '0;
      init_c = 16'hBEEF;
      tick;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_psum", out_psum, hold);
    end
    start = 1'b1;
    out_ready = 1'b1;
    tick;
    start = 1'b0;
    out_ready = 1'b0;
    chk("bp_start_ignored", {out_valid, busy}, 0);
    tick;
    chk("bp_idle_stays", busy, 0);

    // signed wrap
    va[0] = 4'd15; vb[0] = 4'd7;
    run_job(1, 16'h7FF0, 0, cyc, saw);
    chk("wrap_psum", out_psum, 16'h8059);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // reset during WAIT of term 2
    va[0] = 4'd3; vb[0] = 4'd3;
    start = 1'b1;
    len = 8'd3;
    init_c = 16'h0040;
    in_valid = 1'b1;
    in_a = 4'd3;
    in_b = 4'd3;
    tick;
    start = 1'b0;
    repeat (4) tick;
    in_valid = 1'b0;
    chk("mid_in_wait", {in_ready, busy}, 2'b01);
    reset_n = 1'b0;
    tick;
    reset_n = 1'b1;
    chk("mid_rst_ctl", {in_ready, out_valid, busy}, 0);
    chk("mid_rst_psum", {out_psum, mac_c}, 0);
    chk("mid_rst_ab", {mac_a, mac_b}, 0);
    va[0] = 4'd2; vb[0] = 4'd3;
    va[1] = 4'd4; vb[1] = 4'hE;
    run_job(2, 16'h0005, 0, cyc, saw);
    chk("mid_new_psum", out_psum, 16'h0003);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;

    // latency sweep, MAC_LAT 0 and 2
    for (int i = 0; i < 4; i++) begin
      sa[i] = 4'($urandom);
      sb[i] = 4'($urandom);
      va[i] = sa[i];
      vb[i] = sb[i];
    end
    init_s = 16'($urandom);
    exp = model(4, init_s);
    len_s = 8'd4;
    start_s = 1'b1;
    tick;
    start_s = 1'b0;
    c0c = 0;
    c2c = 0;
    for (int c = 1; c < 40; c++) begin
      if (ov_l0 && c0c == 0) c0c = c;
      if (ov_l2 && c2c == 0) c2c = c;
      if (c0c == 0 || c2c == 0) tick;
    end
    chk("lat0_latency", 32'(c0c), 9);
    chk("lat2_latency", 32'(c2c), 17);
    chk("lat0_psum", ps_l0, exp);
    chk("lat2_psum", ps_l2, exp);
    out_ready_s = 1'b1;
    tick;
    chk("lat_release", {busy_l0, busy_l2}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
